imm_encoder: RTL and testbench

Pipelined immediate encoder for the RV32 core tool path. It takes a 32-bit immediate value, an immediate-format select, and a base instruction word. It inserts the immediate into the instruction bits using the exact inverse of the core's immediate-extraction bit mapping, and flags any value that cannot be represented. It sits between the program loader / self-modifying-code path and instruction memory, using valid/ready on both sides.

---
 rtl/imm_encoder.sv | 176 +++++++++++++++++
 tb/tb_imm_encoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: inserts a 32-bit immediate into an RV32 instruction word
// using the inverse of the core's extraction mapping, with range/alignment/format flags.
module imm_encoder (
    input  logic        clock,
    input  logic        nReset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [2:0]  fmt,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err_range,
    output logic        err_align,
    output logic        err_fmt,
    output logic [15:0] word_count,
    output logic [7:0]  err_count
);

    // Stage 1: registered request
    logic        v1_q, v1_d;
    logic [31:0] value1_q, value1_d;
    logic [2:0]  fmt1_q, fmt1_d;
    logic [31:0] base1_q, base1_d;

    // Stage 2: registered encoded word and flags
    logic        v2_q, v2_d;
    logic [31:0] instr_q, instr_d;
    logic        err_range_q, err_range_d;
    logic        err_align_q, err_align_d;
    logic        err_fmt_q, err_fmt_d;

    logic [15:0] word_count_q, word_count_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        adv1, adv2, out_hs;
    logic [31:0] enc_instr;
    logic        enc_range, enc_align, enc_fmt;
    logic        sext_11, sext_12, sext_18;

    // Handshake control; in_ready also forced low while reset is held
    always_comb begin
        adv2     = !v2_q || out_ready;
        adv1     = !v1_q || adv2;
        in_ready = nReset && adv1;
        out_hs   = v2_q && out_ready;
    end

    // Encode the stage-1 request: bit scatter plus representability checks
    always_comb begin
        sext_11   = (&value1_q[31:11]) || !(|value1_q[31:11]);
        sext_12   = (&value1_q[31:12]) || !(|value1_q[31:12]);
        sext_18   = (&value1_q[31:18]) || !(|value1_q[31:18]);
        enc_instr = base1_q;
        enc_range = 1'b0;
        enc_align = 1'b0;
        enc_fmt   = 1'b0;
        case (fmt1_q)
            3'b000: begin
                enc_instr[31:20] = value1_q[11:0];
                enc_range        = !sext_11;
            end
            3'b001: begin
                enc_instr[31:20] = value1_q[11:0];
                enc_range        = |value1_q[31:12];
            end
            3'b010: begin
                enc_instr[31:25] = value1_q[11:5];
                enc_instr[11:7]  = value1_q[4:0];
                enc_range        = !sext_11;
            end
            3'b100: begin
                enc_instr[31]    = value1_q[12];
                enc_instr[7]     = value1_q[11];
                enc_instr[30:25] = value1_q[10:5];
                enc_instr[11:8]  = value1_q[4:1];
                enc_range        = !sext_12;
                enc_align        = value1_q[0];
            end
            3'b101: begin
                enc_instr[31]    = value1_q[18];
                enc_instr[20:14] = value1_q[17:11];
                enc_instr[30:21] = value1_q[10:1];
                enc_range        = !sext_18;
                enc_align        = value1_q[0];
            end
            3'b110: begin
                enc_instr[31:12] = value1_q[31:12];
                enc_align        = |value1_q[11:0];
            end
            default: begin
                enc_fmt = 1'b1;
            end
        endcase
    end

    // Next-state for both pipeline stages and the handshake counters
    always_comb begin
        v1_d         = v1_q;
        value1_d     = value1_q;
        fmt1_d       = fmt1_q;
        base1_d      = base1_q;
        v2_d         = v2_q;
        instr_d      = instr_q;
        err_range_d  = err_range_q;
        err_align_d  = err_align_q;
        err_fmt_d    = err_fmt_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                value1_d = value;
                fmt1_d   = fmt;
                base1_d  = base;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                instr_d     = enc_instr;
                err_range_d = enc_range;
                err_align_d = enc_align;
                err_fmt_d   = enc_fmt;
            end
        end
        if (out_hs) begin
            word_count_d = word_count_q + 16'd1;
            if ((err_range_q || err_align_q || err_fmt_q) && err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!nReset) begin
            v1_q         <= 1'b0;
            value1_q     <= '0;
            fmt1_q       <= '0;
            base1_q      <= '0;
            v2_q         <= 1'b0;
            instr_q      <= '0;
            err_range_q  <= 1'b0;
            err_align_q  <= 1'b0;
            err_fmt_q    <= 1'b0;
            word_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            v1_q         <= v1_d;
            value1_q     <= value1_d;
            fmt1_q       <= fmt1_d;
            base1_q      <= base1_d;
            v2_q         <= v2_d;
            instr_q      <= instr_d;
            err_range_q  <= err_range_d;
            err_align_q  <= err_align_d;
            err_fmt_q    <= err_fmt_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // Outputs come straight from stage 2
    always_comb begin
        out_valid  = v2_q;
        instr      = instr_q;
        err_range  = err_range_q;
        err_align  = err_align_q;
        err_fmt    = err_fmt_q;
        word_count = word_count_q;
        err_count  = err_count_q;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder with a per-bit reference model and scoreboard.
module tb_imm_encoder;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] value = '0;
    logic [2:0]  fmt = '0;
    logic [31:0] base = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        err_range, err_align, err_fmt;
    logic [15:0] word_count;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clock      (clock),
        .nReset     (nReset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .value      (value),
        .fmt        (fmt),
        .base       (base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .err_range  (err_range),
        .err_align  (err_align),
        .err_fmt    (err_fmt),
        .word_count (word_count),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic        er, ea, ef;
        logic [31:0] val;
        logic [2:0]  f;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_lat = 0;
    logic        last_acc = 1'b0;
    logic [31:0] last_instr = '0;
    logic [2:0]  last_flags = '0;
    logic        s_in_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [15:0] mc_words = '0;
    logic [7:0]  mc_errs = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Which value bit lands in instruction bit i for format f (-1: taken from base)
    function automatic int src_bit(input logic [2:0] f, input int i);
        case (f)
            3'b000, 3'b001: return (i >= 20) ? i - 20 : -1;
            3'b010: begin
                if (i >= 25) return i - 20;
                if (i >= 7 && i <= 11) return i - 7;
                return -1;
            end
            3'b100: begin
                if (i == 31) return 12;
                if (i >= 25) return i - 20;
                if (i >= 8 && i <= 11) return i - 7;
                if (i == 7) return 11;
                return -1;
            end
            3'b101: begin
                if (i == 31) return 18;
                if (i >= 21) return i - 20;
                if (i >= 14) return i - 3;
                return -1;
            end
            3'b110: return (i >= 12) ? i : -1;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] v, input logic [2:0] f,
                                   input logic [31:0] b);
        exp_t e;
        int   sv;
        int   s;
        sv = $signed(v);
        e.instr = b;
        for (int i = 0; i < 32; i++) begin
            s = src_bit(f, i);
            if (s >= 0) e.instr[i] = v[s];
        end
        e.ef = (f == 3'b011) || (f == 3'b111);
        case (f)
            3'b000, 3'b010: e.er = !(sv >= -2048 && sv <= 2047);
            3'b001:         e.er = (v > 32'd4095);
            3'b100:         e.er = !(sv >= -4096 && sv <= 4095);
            3'b101:         e.er = !(sv >= -262144 && sv <= 262143);
            default:        e.er = 1'b0;
        endcase
        case (f)
            3'b100, 3'b101: e.ea = (v % 2) != 0;
            3'b110:         e.ea = (v % 4096) != 0;
            default:        e.ea = 1'b0;
        endcase
        e.val = v;
        e.f   = f;
        e.cyc = 0;
        return e;
    endfunction

    // The core's immediate extraction, used for the round-trip invariant
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f);
        logic [11:0] t12;
        logic [12:0] t13;
        logic [18:0] t19;
        int          r;
        case (f)
            3'b000: begin t12 = w[31:20]; r = $signed(t12); end
            3'b001: r = {20'b0, w[31:20]};
            3'b010: begin t12 = {w[31:25], w[11:7]}; r = $signed(t12); end
            3'b100: begin t13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = $signed(t13); end
            3'b101: begin t19 = {w[31], w[20:14], w[30:21], 1'b0}; r = $signed(t19); end
            default: r = {w[31:12], 12'b0};
        endcase
        return r;
    endfunction

    task automatic cycle();
        exp_t e, m;
        logic acc, hs, hs_err;
        hs_err = 1'b0;
        @(negedge clock);
        s_in_ready = in_ready;
        if (prev_stall && nReset) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_instr", instr, prev_instr);
        end
        acc = nReset && in_valid && in_ready;
        hs  = nReset && out_valid && out_ready;
        prev_stall = nReset && out_valid && !out_ready;
        prev_instr = instr;
        last_acc = acc;
        if (hs) begin
            last_instr = instr;
            last_flags = {err_range, err_align, err_fmt};
            if (sb.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                hs_err = e.er || e.ea || e.ef;
                check("instr", instr, e.instr);
                check("flags", {29'b0, err_range, err_align, err_fmt},
                      {29'b0, e.er, e.ea, e.ef});
                if (!hs_err) check("roundtrip", extract(instr, e.f), e.val);
                last_lat = cyc - e.cyc;
            end
        end
        if (acc) begin
            m = model(value, fmt, base);
            m.cyc = cyc;
            sb.push_back(m);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (hs) begin
            mc_words = mc_words + 16'd1;
            if (hs_err && mc_errs != 8'hFF) mc_errs = mc_errs + 8'd1;
        end
        check("word_count", {16'b0, word_count}, {16'b0, mc_words});
        check("err_count", {24'b0, err_count}, {24'b0, mc_errs});
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_flags", {29'b0, err_range, err_align, err_fmt}, 32'd0);
        check("rst_word_count", {16'b0, word_count}, 32'd0);
        check("rst_err_count", {24'b0, err_count}, 32'd0);
        sb.delete();
        mc_words = '0;
        mc_errs = '0;
        prev_stall = 1'b0;
        nReset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic [2:0] f, input logic [31:0] b);
        in_valid = 1'b1;
        value = v;
        fmt = f;
        base = b;
        last_acc = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) cycle();
        if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) cycle();
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
        cycle();
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] v;
        int          sv;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin sv = int'($urandom_range(0, 8191)) - 4096; v = sv; end
            2: begin sv = int'($urandom_range(0, 1 << 20)) - (1 << 19); v = sv; end
            default: v = $urandom & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 0) v[0] = 1'b0;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_n;
        do_reset();

        // I-format with latency check
        out_ready = 1'b1;
        send(32'hFFFFF800, 3'b000, 32'h00000013);
        drain();
        check("iformat_instr", last_instr, 32'h80000013);
        check("iformat_flags", {29'b0, last_flags}, 32'd0);
        check("iformat_latency", last_lat, 32'd2);

        // Branch good and bad
        send(32'h00000FFE, 3'b100, 32'h00000063);
        drain();
        check("branch_instr", last_instr, 32'h7E000FE3);
        check("branch_flags", {29'b0, last_flags}, 32'd0);
        send(32'h00001001, 3'b100, 32'h00000063);
        drain();
        check("branch_bad_flags", {29'b0, last_flags}, 32'b110);
        check("branch_err_count", {24'b0, err_count}, 32'd1);

        // auipc and illegal format
        send(32'h12345678, 3'b110, 32'h00000017);
        drain();
        check("auipc_instr", last_instr, 32'h12345017);
        check("auipc_flags", {29'b0, last_flags}, 32'b010);
        send(32'h12345678, 3'b111, 32'hDEADBEEF);
        drain();
        check("badfmt_instr", last_instr, 32'hDEADBEEF);
        check("badfmt_flags", {29'b0, last_flags}, 32'b001);

        // Backpressure: two accepted, third refused, then all drain in order
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        value = 32'h00000123; fmt = 3'b000; base = 32'h00000013;
        cycle();
        value = 32'h00000456; fmt = 3'b010; base = 32'h00000023;
        cycle();
        value = 32'h00000ABC; fmt = 3'b001; base = 32'h00000003;
        cycle();
        check("full_in_ready", {31'b0, s_in_ready}, 32'd0);
        cycle();
        check("full_in_ready2", {31'b0, s_in_ready}, 32'd0);
        out_ready = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 10 && !last_acc; i++) cycle();
        if (!last_acc) check("third_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        drain();
        check("bp_word_count", {16'b0, word_count}, 32'd3);

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        send(32'h00000010, 3'b000, 32'h00000013);
        send(32'h00000020, 3'b000, 32'h00000013);
        do_reset();
        out_ready = 1'b1;
        cycle();
        check("post_rst_no_out", {31'b0, out_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            value = rand_value();
            fmt = 3'($urandom_range(0, 7));
            base = $urandom;
            cycle();
        end
        in_valid = 1'b0;
        drain();

        // word_count wrap
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        fmt = 3'b000;
        acc_n = 0;
        for (int i = 0; i < 70000 && acc_n < 65537; i++) begin
            value = 32'($urandom_range(0, 2047));
            base = $urandom;
            cycle();
            if (last_acc) acc_n++;
        end
        in_valid = 1'b0;
        drain();
        check("wc_wrap", {16'b0, word_count}, 32'd1);

        // err_count saturation
        in_valid = 1'b1;
        fmt = 3'b100;
        acc_n = 0;
        for (int i = 0; i < 400 && acc_n < 300; i++) begin
            value = $urandom | 32'h1;
            base = $urandom;
            cycle();
            if (last_acc) acc_n++;
        end
        in_valid = 1'b0;
        drain();
        check("ec_sat", {24'b0, err_count}, 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
